// File: rtl/game_state_ctrl.sv
// Game-control stage for the VGA screen block: START -> PLAY -> WIN/LOSE -> START.
// Define GAME_TIMEOUT_EN to enable the PLAY time limit.
module game_state_ctrl #(
  parameter logic [11:0] TH1        = 12'd512,
  parameter logic [11:0] TH2        = 12'd1024,
  parameter logic [11:0] TH3        = 12'd2048,
  parameter int          WIN_HOLD   = 4,
  parameter int          LOSE_HOLD  = 6,
  parameter int          SHOW_TICKS = 4,
  parameter int          TIME_LIMIT = 40
) (
  input  logic        clk_26,
  input  logic        rst,
  input  logic        btn_start,
  input  logic [11:0] mic_level,
  output logic [1:0]  state,
  output logic [3:0]  volume,
  output logic [5:0]  time_left
);

  localparam int HI_W   = $clog2(WIN_HOLD + 1);
  localparam int LO_W   = $clog2(LOSE_HOLD + 1);
  localparam int SHOW_W = $clog2(SHOW_TICKS + 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_LOSE  = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          vol_q, vol_d;
  logic [HI_W-1:0]     hi_cnt_q, hi_cnt_d;
  logic [LO_W-1:0]     lo_cnt_q, lo_cnt_d;
  logic [SHOW_W-1:0]   show_cnt_q, show_cnt_d;
  logic                btn_q;
  logic [1:0]          lvl;
  logic                start_edge;

`ifdef GAME_TIMEOUT_EN
  logic [5:0]          time_q, time_d;
  assign time_left = time_q;
`else
  wire  [5:0]          unused_time_limit = 6'(TIME_LIMIT);
  assign time_left = 6'd0;
`endif

  // Equal-to-threshold takes the higher level.
  always_comb begin
    if (mic_level >= TH3)      lvl = 2'd3;
    else if (mic_level >= TH2) lvl = 2'd2;
    else if (mic_level >= TH1) lvl = 2'd1;
    else                       lvl = 2'd0;
  end

  assign start_edge = btn_start & ~btn_q;
  assign state      = state_q;
  assign volume     = {2'b00, vol_q};

  always_comb begin
    state_d    = state_q;
    vol_d      = 2'd0;
    hi_cnt_d   = hi_cnt_q;
    lo_cnt_d   = lo_cnt_q;
    show_cnt_d = show_cnt_q;
`ifdef GAME_TIMEOUT_EN
    time_d     = time_q;
`endif
    case (state_q)
      ST_START: begin
        if (start_edge) begin
          state_d  = ST_PLAY;
          hi_cnt_d = '0;
          lo_cnt_d = '0;
`ifdef GAME_TIMEOUT_EN
          time_d   = 6'(TIME_LIMIT);
`endif
        end
      end
      ST_PLAY: begin
        vol_d = lvl;
        if (lvl == 2'd3 && hi_cnt_q == HI_W'(WIN_HOLD - 1)) begin
          state_d    = ST_WIN;
          show_cnt_d = '0;
          vol_d      = 2'd0;
        end else if (lvl == 2'd0 && lo_cnt_q == LO_W'(LOSE_HOLD - 1)) begin
          state_d    = ST_LOSE;
          show_cnt_d = '0;
          vol_d      = 2'd0;
        end
`ifdef GAME_TIMEOUT_EN
        else if (time_q == 6'd1) begin
          state_d    = ST_LOSE;
          show_cnt_d = '0;
          vol_d      = 2'd0;
        end
`endif
        else begin
          hi_cnt_d = (lvl == 2'd3) ? hi_cnt_q + 1'b1 : '0;
          lo_cnt_d = (lvl == 2'd0) ? lo_cnt_q + 1'b1 : '0;
`ifdef GAME_TIMEOUT_EN
          time_d   = time_q - 6'd1;
`endif
        end
      end
      ST_WIN, ST_LOSE: begin
        // time_left deliberately holds here; it reloads only on START->PLAY.
        show_cnt_d = show_cnt_q + 1'b1;
        if (show_cnt_q == SHOW_W'(SHOW_TICKS - 1)) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  // btn_q resets high so a button held through reset cannot start a game.
  always_ff @(posedge clk_26 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      vol_q      <= 2'd0;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      show_cnt_q <= '0;
      btn_q      <= 1'b1;
`ifdef GAME_TIMEOUT_EN
      time_q     <= 6'd0;
`endif
    end else begin
      state_q    <= state_d;
      vol_q      <= vol_d;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      show_cnt_q <= show_cnt_d;
      btn_q      <= btn_start;
`ifdef GAME_TIMEOUT_EN
      time_q     <= time_d;
`endif
    end
  end

endmodule
